// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one physical memory port between the instruction-fetch requester
// (i_*) and the load/store data requester (d_*). One request is latched per
// transaction and held on the pmem_* bus until memory answers. The answer is
// then returned to the requester that owns the transaction. When both
// requesters contend in IDLE, the one that lost the previous tie wins.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   i_read, i_address     fetch request (read only), held until i_resp
//   i_rdata, i_resp       fetch response (rdata is zero unless i_resp)
//   d_read, d_write       data request, held until d_resp (both = write)
//   d_address, d_wdata    data address / write data
//   d_byte_enable         write mask, [0] low byte, [1] high byte
//   d_rdata, d_resp       data response (rdata is zero unless d_resp)
//   pmem_*                physical memory port, driven from latched registers
//   timeout_err           sticky abort flag
//
// Optional feature: define MEM_ARB_TIMEOUT_EN to abort a granted transaction
// after TIMEOUT_CYCLES cycles without pmem_resp. Without it, a grant waits
// forever and timeout_err is tied to 0.
// ----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 32'd255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_read,
    input  logic [15:0] i_address,
    output logic [15:0] i_rdata,
    output logic        i_resp,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [15:0] d_address,
    input  logic [15:0] d_wdata,
    input  logic [1:0]  d_byte_enable,
    output logic [15:0] d_rdata,
    output logic        d_resp,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic [15:0] pmem_address,
    output logic [15:0] pmem_wdata,
    output logic [1:0]  pmem_byte_enable,
    input  logic [15:0] pmem_rdata,
    input  logic        pmem_resp,
    output logic        timeout_err
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT_I = 2'd1;
    localparam logic [1:0] ST_GRANT_D = 2'd2;

    // last_grant encoding: which requester won the most recent tie
    localparam logic LG_I = 1'b0;
    localparam logic LG_D = 1'b1;

    // Reject out-of-range timeout settings at elaboration
    if (TIMEOUT_CYCLES < 32'd1 || TIMEOUT_CYCLES > 32'd65535) begin : g_bad_timeout
        $error("mem_port_arbiter: TIMEOUT_CYCLES must be within 1..65535");
    end

    logic [1:0]  state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        read_q, read_d;
    logic        write_q, write_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [1:0]  be_q, be_d;

    logic        d_req_s;
    logic        tie_s;
    logic        take_i_s;
    logic        take_d_s;
    logic        grant_i_s;
    logic        grant_d_s;
    logic        grant_done_s;
    logic        timeout_hit_s;

    assign d_req_s      = d_read | d_write;
    assign grant_i_s    = (state_q == ST_GRANT_I);
    assign grant_d_s    = (state_q == ST_GRANT_D);
    assign tie_s        = (state_q == ST_IDLE) & i_read & d_req_s;
    assign grant_done_s = (grant_i_s | grant_d_s) & (pmem_resp | timeout_hit_s);

    // Arbitration decision in IDLE: single requester wins outright, a tie
    // goes to the requester that lost the previous tie
    always_comb begin
        take_i_s = 1'b0;
        take_d_s = 1'b0;
        if (state_q != ST_IDLE) begin
            take_i_s = 1'b0;
            take_d_s = 1'b0;
        end else if (tie_s) begin
            take_i_s = (last_grant_q == LG_D);
            take_d_s = (last_grant_q == LG_I);
        end else begin
            take_i_s = i_read;
            take_d_s = d_req_s;
        end
    end

    // Next-state, request latch and tie-history update
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        read_d       = read_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        // Only contested grants move the tie history
        if (tie_s) begin
            last_grant_d = take_i_s ? LG_I : LG_D;
        end else begin
            last_grant_d = last_grant_q;
        end
        case (state_q)
            ST_IDLE: begin
                if (take_i_s) begin
                    state_d = ST_GRANT_I;
                    read_d  = 1'b1;
                    write_d = 1'b0;
                    addr_d  = i_address;
                    wdata_d = 16'h0000;
                    be_d    = 2'b11;
                end else if (take_d_s) begin
                    // read+write together is illegal and resolves to a write
                    state_d = ST_GRANT_D;
                    read_d  = ~d_write;
                    write_d = d_write;
                    addr_d  = d_address;
                    wdata_d = d_wdata;
                    be_d    = d_byte_enable;
                end else begin
                    state_d = ST_IDLE;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                end
            end
            ST_GRANT_I, ST_GRANT_D: begin
                if (grant_done_s) begin
                    state_d = ST_IDLE;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                read_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase
    end

    // FSM and latched-request registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= LG_D;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            addr_q       <= 16'h0000;
            wdata_q      <= 16'h0000;
            be_q         <= 2'b00;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            read_q       <= read_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 32'd1);

    logic [15:0] wait_q, wait_d;
    logic        timeout_err_q;

    // wait_q counts grant cycles already spent, so the current grant cycle
    // is number wait_q+1; abort on the TIMEOUT_CYCLES-th one unless memory
    // answers in that same cycle
    assign timeout_hit_s = (grant_i_s | grant_d_s) & ~pmem_resp & (wait_q == TIMEOUT_LAST);

    // Wait counter: cleared on grant entry, advanced each unanswered grant cycle
    always_comb begin
        wait_d = wait_q;
        if (take_i_s | take_d_s) begin
            wait_d = 16'h0000;
        end else if ((grant_i_s | grant_d_s) & ~pmem_resp) begin
            wait_d = wait_q + 16'd1;
        end else begin
            wait_d = wait_q;
        end
    end

    // Wait counter and sticky abort flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q        <= 16'h0000;
            timeout_err_q <= 1'b0;
        end else begin
            wait_q        <= wait_d;
            timeout_err_q <= timeout_err_q | timeout_hit_s;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_hit_s = 1'b0;
    assign timeout_err   = 1'b0;
`endif

    assign pmem_read        = read_q;
    assign pmem_write       = write_q;
    assign pmem_address     = addr_q;
    assign pmem_wdata       = wdata_q;
    assign pmem_byte_enable = be_q;

    // Responses are combinational from memory, gated by ownership; an
    // aborted transaction returns zero data because pmem_resp is low then
    assign i_resp  = grant_i_s & (pmem_resp | timeout_hit_s);
    assign d_resp  = grant_d_s & (pmem_resp | timeout_hit_s);
    assign i_rdata = (grant_i_s & pmem_resp) ? pmem_rdata : 16'h0000;
    assign d_rdata = (grant_d_s & pmem_resp) ? pmem_rdata : 16'h0000;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        i_read = 1'b0;
    logic [15:0] i_address = 16'h0000;
    logic [15:0] i_rdata;
    logic        i_resp;
    logic        d_read = 1'b0;
    logic        d_write = 1'b0;
    logic [15:0] d_address = 16'h0000;
    logic [15:0] d_wdata = 16'h0000;
    logic [1:0]  d_byte_enable = 2'b00;
    logic [15:0] d_rdata;
    logic        d_resp;
    logic        pmem_read;
    logic        pmem_write;
    logic [15:0] pmem_address;
    logic [15:0] pmem_wdata;
    logic [1:0]  pmem_byte_enable;
    logic [15:0] pmem_rdata = 16'h0000;
    logic        pmem_resp = 1'b0;
    logic        timeout_err;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_byte_enable(d_byte_enable), .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_byte_enable(pmem_byte_enable),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp), .timeout_err(timeout_err)
    );

    typedef struct {
        logic [15:0] addr;
        logic        wr;
        logic [15:0] wdata;
        logic [1:0]  be;
        logic [15:0] rdata;
    } exp_t;

    exp_t qi[$];
    exp_t qd[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   i_cnt  = 0;
    int   d_cnt  = 0;

    // physical memory (environment) and the bench's own reference copy
    logic [15:0] pmem_arr [0:255];
    logic [15:0] ref_mem  [0:255];
    bit          auto_mem = 1'b0;
    bit          busy = 1'b0;
    int          lat = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic check_txn(input string who, input exp_t e, input logic [15:0] rd);
        chk({who, "_addr"}, pmem_address, e.addr);
        chk({who, "_pmem_write"}, {15'd0, pmem_write}, {15'd0, e.wr});
        chk({who, "_pmem_read"}, {15'd0, pmem_read}, {15'd0, ~e.wr});
        chk({who, "_be"}, {14'd0, pmem_byte_enable}, {14'd0, e.be});
        if (e.wr) chk({who, "_wdata"}, pmem_wdata, e.wdata);
        else      chk({who, "_rdata"}, rd, e.rdata);
    endtask

    // scoreboard monitor: pops one expectation per response pulse
    always @(negedge clk) begin
        if (rst_n && i_resp) begin
            i_cnt++;
            if (qi.size() == 0) begin
                checks++; errors++;
                $display("FAIL i_unexpected: got i_resp=1 expected no response at %0t", $time);
            end else begin
                mon_e = qi.pop_front();
                check_txn("i", mon_e, i_rdata);
            end
        end
        if (rst_n && d_resp) begin
            d_cnt++;
            if (qd.size() == 0) begin
                checks++; errors++;
                $display("FAIL d_unexpected: got d_resp=1 expected no response at %0t", $time);
            end else begin
                mon_e = qd.pop_front();
                check_txn("d", mon_e, d_rdata);
            end
        end
    end

    // random-latency memory responder, active only in auto mode
    always @(posedge clk) begin
        #1;
        if (auto_mem) begin
            pmem_resp  = 1'b0;
            pmem_rdata = 16'h0000;
            if (pmem_read || pmem_write) begin
                if (!busy) begin
                    busy = 1'b1;
                    lat  = $urandom_range(0, 3);
                end
                if (lat == 0) begin
                    busy      = 1'b0;
                    pmem_resp = 1'b1;
                    if (pmem_write) begin
                        if (pmem_byte_enable[1]) pmem_arr[pmem_address[7:0]][15:8] = pmem_wdata[15:8];
                        if (pmem_byte_enable[0]) pmem_arr[pmem_address[7:0]][7:0]  = pmem_wdata[7:0];
                    end else begin
                        pmem_rdata = pmem_arr[pmem_address[7:0]];
                    end
                end else begin
                    lat--;
                end
            end
        end
    end

    task automatic wait_resp(input bit is_d);
        int n;
        for (n = 0; n < 300; n++) begin
            @(negedge clk);
            if (is_d ? d_resp : i_resp) break;
        end
        if (n == 300) begin
            checks++; errors++;
            $display("FAIL %s_wait: got no response expected one within 300 cycles", is_d ? "d" : "i");
        end
    endtask

    task automatic fetch_proc(input int n_txn);
        logic [15:0] r;
        exp_t e;
        for (int k = 0; k < n_txn; k++) begin
            repeat ($urandom_range(0, 2)) step();
            step();
            r = 16'($urandom);
            i_address = {r[15:8], 1'b0, r[6:0]};
            i_read    = 1'b1;
            e.addr = i_address; e.wr = 1'b0; e.wdata = 16'h0000; e.be = 2'b11;
            e.rdata = ref_mem[i_address[7:0]];
            qi.push_back(e);
            wait_resp(1'b0);
            step();
            i_read = 1'b0;
        end
    endtask

    task automatic data_proc(input int n_txn);
        logic [15:0] r;
        int op;
        exp_t e;
        for (int k = 0; k < n_txn; k++) begin
            repeat ($urandom_range(0, 2)) step();
            step();
            r  = 16'($urandom);
            op = $urandom_range(0, 3);
            d_address     = {r[15:8], 1'b1, r[6:0]};
            d_wdata       = 16'($urandom);
            d_byte_enable = 2'($urandom);
            d_read        = (op != 2);
            d_write       = (op >= 2);
            e.addr = d_address; e.wr = (op >= 2); e.wdata = d_wdata; e.be = d_byte_enable;
            e.rdata = ref_mem[d_address[7:0]];
            if (e.wr) begin
                if (e.be[1]) ref_mem[e.addr[7:0]][15:8] = e.wdata[15:8];
                if (e.be[0]) ref_mem[e.addr[7:0]][7:0]  = e.wdata[7:0];
            end
            qd.push_back(e);
            wait_resp(1'b1);
            step();
            d_read  = 1'b0;
            d_write = 1'b0;
        end
    endtask

    initial begin
        exp_t e;
        int   c0;
        for (int a = 0; a < 256; a++) begin
            pmem_arr[a] = 16'(a * 257) ^ 16'h5A5A;
            ref_mem[a]  = 16'(a * 257) ^ 16'h5A5A;
        end

        // reset state
        #3 rst_n = 1'b0;
        #1;
        chk("rst_pmem_read", {15'd0, pmem_read}, 16'h0000);
        chk("rst_pmem_write", {15'd0, pmem_write}, 16'h0000);
        chk("rst_pmem_address", pmem_address, 16'h0000);
        chk("rst_timeout_err", {15'd0, timeout_err}, 16'h0000);
        repeat (2) sample();
        #1 rst_n = 1'b1;

        // single fetch, memory answers in cycle 3
        step();
        i_read = 1'b1; i_address = 16'h0040;
        e.addr = 16'h0040; e.wr = 1'b0; e.wdata = 16'h0000; e.be = 2'b11; e.rdata = 16'h1234;
        qi.push_back(e);
        sample(); chk("t1_c0_strobe", {15'd0, pmem_read}, 16'h0000);
        step(); sample();
        chk("t1_c1_strobe", {15'd0, pmem_read}, 16'h0001);
        chk("t1_c1_addr", pmem_address, 16'h0040);
        step(); sample(); chk("t1_c2_resp", {15'd0, i_resp}, 16'h0000);
        step(); pmem_resp = 1'b1; pmem_rdata = 16'h1234;
        sample();
        chk("t1_c3_resp", {15'd0, i_resp}, 16'h0001);
        chk("t1_c3_rdata", i_rdata, 16'h1234);
        step(); pmem_resp = 1'b0; pmem_rdata = 16'h0000; i_read = 1'b0;
        sample();
        chk("t1_c4_strobe", {15'd0, pmem_read}, 16'h0000);
        chk("t1_c4_rdata_idle", i_rdata, 16'h0000);

        // two simultaneous pairs: fetch first, then data first
        for (int p = 0; p < 2; p++) begin
            step();
            i_read = 1'b1; i_address = 16'h0011;
            d_read = 1'b1; d_address = 16'h0022; d_byte_enable = 2'b01;
            e.addr = 16'h0011; e.wr = 1'b0; e.be = 2'b11; e.rdata = 16'hAAAA; qi.push_back(e);
            e.addr = 16'h0022; e.wr = 1'b0; e.be = 2'b01; e.rdata = 16'hBBBB; qd.push_back(e);
            step(); sample();
            chk(p == 0 ? "tie1_first_addr" : "tie2_first_addr", pmem_address, p == 0 ? 16'h0011 : 16'h0022);
            step(); pmem_resp = 1'b1; pmem_rdata = (p == 0) ? 16'hAAAA : 16'hBBBB;
            step(); pmem_resp = 1'b0;
            if (p == 0) i_read = 1'b0; else d_read = 1'b0;
            sample(); chk("tie_idle_gap", {15'd0, pmem_read}, 16'h0000);
            step(); sample();
            chk(p == 0 ? "tie1_second_addr" : "tie2_second_addr", pmem_address, p == 0 ? 16'h0022 : 16'h0011);
            pmem_resp = 1'b1; pmem_rdata = (p == 0) ? 16'hBBBB : 16'hAAAA;
            step(); pmem_resp = 1'b0; i_read = 1'b0; d_read = 1'b0;
        end

        // data write with partial mask
        c0 = i_cnt;
        step();
        d_write = 1'b1; d_address = 16'h0101; d_wdata = 16'h00AB; d_byte_enable = 2'b10;
        e.addr = 16'h0101; e.wr = 1'b1; e.wdata = 16'h00AB; e.be = 2'b10; e.rdata = 16'h0000;
        qd.push_back(e);
        step(); sample();
        chk("wr_strobe", {15'd0, pmem_write}, 16'h0001);
        chk("wr_wdata", pmem_wdata, 16'h00AB);
        step(); pmem_resp = 1'b1; pmem_rdata = 16'hFFFF;
        sample(); chk("wr_d_resp", {15'd0, d_resp}, 16'h0001);
        step(); pmem_resp = 1'b0; d_write = 1'b0;
        sample(); chk("wr_d_resp_once", {15'd0, d_resp}, 16'h0000);
        chk("wr_no_i_resp", 16'(i_cnt - c0), 16'h0000);

        // asynchronous reset mid GRANT_D, then a pending fetch wins the tie
        step();
        d_read = 1'b1; d_address = 16'h0200; d_byte_enable = 2'b11;
        step();
        i_read = 1'b1; i_address = 16'h0044;
        sample(); chk("rst_mid_grant_d", pmem_address, 16'h0200);
        #1 pmem_resp = 1'b1; pmem_rdata = 16'hBEEF;
        #1 rst_n = 1'b0;
        #1;
        chk("arst_pmem_read", {15'd0, pmem_read}, 16'h0000);
        chk("arst_pmem_address", pmem_address, 16'h0000);
        chk("arst_pmem_be", {14'd0, pmem_byte_enable}, 16'h0000);
        chk("arst_d_resp", {15'd0, d_resp}, 16'h0000);
        chk("arst_d_rdata", d_rdata, 16'h0000);
        #1 pmem_resp = 1'b0; pmem_rdata = 16'h0000; rst_n = 1'b1;
        e.addr = 16'h0044; e.wr = 1'b0; e.be = 2'b11; e.rdata = 16'h1111; qi.push_back(e);
        e.addr = 16'h0200; e.wr = 1'b0; e.be = 2'b11; e.rdata = 16'h2222; qd.push_back(e);
        step(); sample(); chk("arst_fetch_wins", pmem_address, 16'h0044);
        step(); pmem_resp = 1'b1; pmem_rdata = 16'h1111;
        step(); pmem_resp = 1'b0; i_read = 1'b0;
        step(); sample(); chk("arst_data_next", pmem_address, 16'h0200);
        pmem_resp = 1'b1; pmem_rdata = 16'h2222;
        step(); pmem_resp = 1'b0; d_read = 1'b0;

        // fetch dropped mid-grant still completes exactly once
        c0 = i_cnt;
        step();
        i_read = 1'b1; i_address = 16'h0033;
        e.addr = 16'h0033; e.wr = 1'b0; e.be = 2'b11; e.rdata = 16'h3333; qi.push_back(e);
        step(); i_read = 1'b0;
        step(); pmem_resp = 1'b1; pmem_rdata = 16'h3333;
        step(); pmem_resp = 1'b0;
        repeat (3) step();
        sample();
        chk("drop_resp_count", 16'(i_cnt - c0), 16'h0001);
        chk("drop_idle", {15'd0, pmem_read}, 16'h0000);

`ifdef MEM_ARB_TIMEOUT_EN
        // memory never answers a data read: abort on cycle TO
        step();
        d_read = 1'b1; d_address = 16'h0300; d_byte_enable = 2'b11;
        e.addr = 16'h0300; e.wr = 1'b0; e.be = 2'b11; e.rdata = 16'h0000; qd.push_back(e);
        for (int c = 1; c < int'(TO); c++) begin
            step(); sample(); chk("to_early_resp", {15'd0, d_resp}, 16'h0000);
        end
        step(); sample();
        chk("to_resp", {15'd0, d_resp}, 16'h0001);
        chk("to_rdata", d_rdata, 16'h0000);
        step(); d_read = 1'b0;
        sample();
        chk("to_err_set", {15'd0, timeout_err}, 16'h0001);
        chk("to_strobe_low", {15'd0, pmem_read}, 16'h0000);
        step();
        i_read = 1'b1; i_address = 16'h0050;
        e.addr = 16'h0050; e.wr = 1'b0; e.be = 2'b11; e.rdata = 16'h7777; qi.push_back(e);
        step(); pmem_resp = 1'b1; pmem_rdata = 16'h7777;
        sample(); chk("to_fetch_after", {15'd0, i_resp}, 16'h0001);
        step(); pmem_resp = 1'b0; i_read = 1'b0;
        sample(); chk("to_err_sticky", {15'd0, timeout_err}, 16'h0001);
`else
        sample(); chk("no_timeout_err", {15'd0, timeout_err}, 16'h0000);
`endif

        // randomized contention against the reference memory
        pmem_resp = 1'b0;
        pmem_rdata = 16'h0000;
        auto_mem = 1'b1;
        fork
            fetch_proc(40);
            data_proc(40);
        join
        repeat (4) step();
        chk("qi_empty", 16'(qi.size()), 16'h0000);
        chk("qd_empty", 16'(qd.size()), 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // global watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
